uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter with a registered serial output. It supersedes the combinational bit-select transmit datapath.
- Integrates its own baud-tick counter, bit counter and frame FSM, so no external bit counter is needed.
- Accepts words over a valid/ready handshake and serialises start, data LSB-first, optional parity and 1 or 2 stop bits.
- Sits between the host-side byte source and the tx pin in the UART subsystem.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 434, clk cycles per bit period; legal range >= 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only used when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  host presents a word.
- tx_data  in  DATA_BITS  word to send; sampled only at the accept cycle.
- tx_ready  out  1  block can accept a word this cycle.
- tx_out  out  1  serial line; idles high; registered.
- tx_busy  out  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, tx_out=1, tx_ready=1, tx_busy=0.
  - Baud, bit and shift registers cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high, with no truncated-frame recovery.
- Accept: a transfer occurs on a rising clk edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register.
  - Parity is computed from the latched word.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1, tx_ready=1. On accept -> START.
  - START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_out=shift[0]; shift right at each bit end; DATA_BITS bit periods.
    - With parity enabled -> PARITY, otherwise -> STOP.
  - PARITY: tx_out = ^data XOR PARITY_ODD for one bit period -> STOP.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE.
- Latency: tx_out falls on the first edge after the accept edge, i.e. one cycle after accept.
- Bit timing:
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1; it is restarted at each state entry and wraps at each bit end.
  - Frame length = (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT, where P=1 with parity and 0 without.
- Back-to-back transfers:
  - tx_ready is also high during the final clk cycle of the last stop bit.
  - An accept in that cycle goes STOP -> START directly; the next start bit follows with zero idle cycles.
  - Without an accept in that cycle the FSM goes to IDLE.
- tx_ready is 0 at all other times during a frame. tx_valid/tx_data changes while not ready are ignored.
- tx_valid held high continuously produces continuous frames with no gap.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter, $clog2(DATA_BITS+1) for the bit counter. No overflow paths are reachable.
- tx_out is driven only from a flop, so the line carries no combinational glitches.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
  - Defined: PARITY state is present; frame carries one parity bit, even or odd per PARITY_ODD.
  - Undefined: PARITY state and parity logic are absent; DATA -> STOP directly; PARITY_ODD is ignored.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg: tx_state_e enum (IDLE, START, DATA, PARITY, STOP) and the legal-range constants for DATA_BITS and STOP_BITS.
- One sub-module, uart_baud_tick:
  - Parametrised on CLKS_PER_BIT.
  - Inputs: clk, rst_n, restart.
  - Output: bit_end pulse on the last cycle of each bit period.

Test Plan:
- Reset then idle, defaults: hold rst_n=0 -> tx_out=1, tx_ready=1, tx_busy=0; after release with no tx_valid, all three are unchanged for 1000 cycles.
- Single frame, 8N1, CLKS_PER_BIT=4, tx_data=8'hA5:
  - tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - Start bit begins 1 cycle after accept.
  - tx_busy is high for 40 cycles.
- Back-to-back: tx_valid held high with words 8'h00 then 8'hFF -> second start bit immediately follows the first stop bit (0 idle cycles); tx_ready pulses exactly once per frame, in the final stop cycle.
- Parity, macro defined, PARITY_ODD=0, tx_data=8'h07 -> parity bit = 1; same word with PARITY_ODD=1 -> parity bit = 0; frame length = 11*CLKS_PER_BIT.
- DATA_BITS=5, STOP_BITS=2, tx_data=5'h1B -> data 1,1,0,1,1 then 2 stop periods; frame length = 8*CLKS_PER_BIT.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx_out=1 asynchronously, same cycle; after release the block is in IDLE with tx_ready=1, and a new word is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART transmit path.
package uart_pkg;

    // Legal ranges for the frame-shape parameters.
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Frame FSM states; PARITY is only reachable when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bit end is the final count of the current period.
    assign bit_end = (cnt_q == LAST_CNT);

    // Hold at zero while restarting, wrap at each bit end, otherwise count up.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional parity,
// STOP_BITS stop bits. tx_out comes straight from a flop.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
//
// Handshake: a word is transferred on a rising clk edge where tx_valid && tx_ready.
// tx_ready is high in IDLE and in the final cycle of the last stop bit, so
// a held tx_valid yields back-to-back frames with no idle cycles between them.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam bit PARAMS_OK = (DATA_BITS >= DATA_BITS_MIN) && (DATA_BITS <= DATA_BITS_MAX) &&
                               (STOP_BITS >= STOP_BITS_MIN) && (STOP_BITS <= STOP_BITS_MAX) &&
                               (CLKS_PER_BIT >= 2) && (PARITY_ODD >= 0) && (PARITY_ODD <= 1);

    // Refuse to elaborate with an out-of-range frame shape.
    if (!PARAMS_OK) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter value");
    end

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   tx_out_q, tx_out_d;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // Baud timer is held at zero in IDLE; every later state entry lands on a
    // bit end, where the timer wraps to zero anyway.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(state_q == IDLE),
        .bit_end(bit_end)
    );

    assign tx_out  = tx_out_q;
    assign tx_busy = (state_q != IDLE);

    // Next-state, shift/bit-count updates and the ready handshake.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_ready  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        tx_ready = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An accept overrides the above: from IDLE or the final stop cycle go straight to START.
        if (tx_ready && tx_valid) begin
            state_d   = START;
            shift_d   = tx_data;
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = (^tx_data) ^ PARITY_ODD[0];
`endif
        end
    end

    // Line level for the current state; registered so the pin never glitches.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_q)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = parity_q;
`endif
            default: tx_out_d = 1'b1;
        endcase
    end

    // State, datapath and line registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_out_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_out_q  <= tx_out_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (8N1 at 4 clk/bit, 5-bit two-stop
// odd-parity at 3 clk/bit) checked cycle by cycle against a frame-level model.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] tx_valid;
    logic [8:0] tx_data [2];
    logic [1:0] tx_ready;
    logic [1:0] tx_out;
    logic [1:0] tx_busy;

    int checks = 0;
    int passed = 0;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "watchdog");
    end

    uart_tx_frame #(
        .DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[0]), .tx_data(tx_data[0][7:0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0])
    );

    uart_tx_frame #(
        .DATA_BITS(5), .CLKS_PER_BIT(3), .STOP_BITS(2), .PARITY_ODD(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[1]), .tx_data(tx_data[1][4:0]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1])
    );

    // Per-instance configuration.
    function automatic int cpb(input int idx);
        return (idx == 0) ? 4 : 3;
    endfunction
    function automatic int dbits(input int idx);
        return (idx == 0) ? 8 : 5;
    endfunction
    function automatic int sbits(input int idx);
        return (idx == 0) ? 1 : 2;
    endfunction
    function automatic int podd(input int idx);
        return (idx == 0) ? 0 : 1;
    endfunction
    function automatic int flen(input int idx);
        return (1 + dbits(idx) + PBITS + sbits(idx)) * cpb(idx);
    endfunction

    // Sends words with tx_valid held high and checks tx_out/tx_busy/tx_ready every
    // cycle from the first accept until two cycles after the last frame ends.
    task automatic run_stream(input int idx, input logic [8:0] words[$], input string name);
        logic [0:0] exp_q[$];
        int         len;
        int         total;
        int         n;
        int         ones;
        int         j;
        logic       exp_out;
        logic       exp_busy;
        logic       exp_ready;
        len   = flen(idx);
        n     = words.size();
        total = n * len;
        foreach (words[w]) begin
            ones = 0;
            for (int r = 0; r < cpb(idx); r++) exp_q.push_back(1'b0);
            for (int b = 0; b < dbits(idx); b++) begin
                ones += int'(words[w][b]);
                for (int r = 0; r < cpb(idx); r++) exp_q.push_back(words[w][b]);
            end
            for (int p = 0; p < PBITS; p++) begin
                for (int r = 0; r < cpb(idx); r++) exp_q.push_back(1'((ones % 2) ^ podd(idx)));
            end
            for (int s = 0; s < sbits(idx) * cpb(idx); s++) exp_q.push_back(1'b1);
        end
        @(negedge clk);
        tx_valid[idx] = 1'b1;
        tx_data[idx]  = words[0];
        @(posedge clk);
        #1;
        if (n > 1) tx_data[idx] = words[1];
        else       tx_valid[idx] = 1'b0;
        for (int k = 0; k <= total + 1; k++) begin
            @(negedge clk);
            exp_out   = (k == 0 || k > total) ? 1'b1 : exp_q[k-1];
            exp_busy  = (k < total);
            exp_ready = (k < total) ? ((k % len) == len - 1) : 1'b1;
            checks++;
            if (tx_out[idx] !== exp_out)
                $display("FAIL %s tx_out dut%0d cycle %0d: got %b want %b", name, idx, k, tx_out[idx], exp_out);
            else passed++;
            checks++;
            if (tx_busy[idx] !== exp_busy)
                $display("FAIL %s tx_busy dut%0d cycle %0d: got %b want %b", name, idx, k, tx_busy[idx], exp_busy);
            else passed++;
            checks++;
            if (tx_ready[idx] !== exp_ready)
                $display("FAIL %s tx_ready dut%0d cycle %0d: got %b want %b", name, idx, k, tx_ready[idx], exp_ready);
            else passed++;
            if (k < total && (k % len) == len - 1) begin
                @(posedge clk);
                #1;
                j = k / len + 2;
                if (j < n) tx_data[idx] = words[j];
                else       tx_valid[idx] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({tx_out[i], tx_ready[i], tx_busy[i]} !== 3'b110)
                $display("FAIL reset_hold dut%0d out/ready/busy: got %b%b%b want 110", i, tx_out[i], tx_ready[i], tx_busy[i]);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 1000 && !bad; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({tx_out[i], tx_ready[i], tx_busy[i]} !== 3'b110) begin
                    $display("FAIL reset_idle dut%0d cycle %0d out/ready/busy: got %b%b%b want 110",
                             i, c, tx_out[i], tx_ready[i], tx_busy[i]);
                    bad = 1'b1;
                end else passed++;
            end
        end
    endtask

    task automatic test_single_frame();
        logic [8:0] w[$];
        w = '{9'h0A5};
        run_stream(0, w, "single_a5");
        w = '{9'h01B};
        run_stream(1, w, "five_bit_1b");
    endtask

    task automatic test_parity();
        logic [8:0] w[$];
        w = '{9'h007};
        run_stream(0, w, "parity_even_07");
        run_stream(1, w, "parity_odd_07");
    endtask

    task automatic test_back_to_back();
        logic [8:0] w[$];
        w = '{9'h000, 9'h0FF, 9'($urandom_range(0, 255)), 9'($urandom_range(0, 255))};
        run_stream(0, w, "b2b_dut0");
        w = '{9'h000, 9'h01F, 9'($urandom_range(0, 31))};
        run_stream(1, w, "b2b_dut1");
    endtask

    task automatic test_random_gaps();
        logic [8:0] w[$];
        int         idx;
        for (int r = 0; r < 8; r++) begin
            idx = r % 2;
            w = '{9'($urandom_range(0, (1 << dbits(idx)) - 1))};
            run_stream(idx, w, "random_gap");
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] w[$];
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 9'h0A5;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        // Cycle 17 after accept: tx_out carries data bit 3 of 0xA5, which is 0.
        repeat (18) @(negedge clk);
        checks++;
        if ({tx_out[0], tx_busy[0]} !== 2'b01)
            $display("FAIL midreset_pre out/busy: got %b%b want 01", tx_out[0], tx_busy[0]);
        else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_out[0], tx_ready[0], tx_busy[0]} !== 3'b110)
            $display("FAIL midreset_async out/ready/busy: got %b%b%b want 110", tx_out[0], tx_ready[0], tx_busy[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_out[0], tx_ready[0], tx_busy[0]} !== 3'b110)
            $display("FAIL midreset_after out/ready/busy: got %b%b%b want 110", tx_out[0], tx_ready[0], tx_busy[0]);
        else passed++;
        w = '{9'h03C};
        run_stream(0, w, "after_midreset");
    endtask

    // Test sequence and final report.
    initial begin
        tx_valid   = 2'b00;
        tx_data[0] = '0;
        tx_data[1] = '0;
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
